seven_seg_serial_tx: RTL and testbench
======================================

# seven_seg_serial_tx

Serial transmitter that drives the board's seven-segment display from the 32-bit `disp_num` word produced by the display-source mux. It decodes the word into eight hex digits and applies per-digit decimal-point and blank masks. It then shifts the resulting 64-bit segment frame MSB-first into the external shift-register chain and pulses the latch strobe. A new frame is sent only when the displayed content changes, so the display is stable and glitch-free between updates.

## Interface
- `CLK_DIV`, default 2: `seg_clk` half-period in `clk` cycles; legal values are 1 and above.
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `disp_num` input, 32 bits: value to display; nibble i drives digit i, digit 7 is leftmost.
- `point` input, 8 bits: decimal point per digit; 1 lights the point.
- `le` input, 8 bits: blank mask per digit; 1 turns the whole digit off.
- `seg_clk` output, 1 bit: shift clock to the chain; data is sampled on its rising edge.
- `seg_sout` output, 1 bit: serial data.
- `seg_pen` output, 1 bit: latch strobe, active-high.
- `seg_clrn` output, 1 bit: chain clear, active-low.
- `busy` output, 1 bit: high while a frame is in flight.

## Operation
- **Segment byte for digit i:** bit order {dp,g,f,e,d,c,b,a}, active-low.
  - If `le[i]` is 1, the byte is 8'hFF.
  - Otherwise bit 7 is ~`point[i]` and bits 6:0 come from the hex table below.
- **Hex table (bits 6:0 plus an unlit dp, as full bytes for digits 0 to F):** C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- **Frame:** {byte7, byte6, …, byte0}, 64 bits, shifted MSB-first, so bit 63 goes first.
- **`snap`:** {disp_num, point, le}, 48 bits.
  - `last` holds the snap of the last completed frame.
  - A `valid` flag is cleared by reset.
- **FSM states: IDLE, SHIFT, LATCH.**
  - **IDLE → SHIFT:** taken when `valid`=0 or `snap`≠`last`.
    - In the same cycle, capture the frame into a 64-bit shift register and copy `snap` into `pending`.
    - Clear the bit counter (7 bits) and the divider.
  - **SHIFT, per bit:**
    - Present the frame MSB on `seg_sout`.
    - Hold `seg_clk`=0 for CLK_DIV cycles, then `seg_clk`=1 for CLK_DIV cycles.
    - At the end of the high phase, shift left and increment the counter.
    - After bit 63's high phase completes, go to LATCH.
  - **LATCH:**
    - Hold `seg_clk`=0 and `seg_pen`=1 for 2·CLK_DIV cycles.
    - Then set `last`←`pending` and `valid`←1, and return to IDLE.
- **Input sampling:** inputs are sampled only in IDLE.
  - Changes during SHIFT or LATCH are not lost: they are detected on return to IDLE, and exactly one further frame is sent with the latest value.
  - Multiple changes during one frame produce one follow-up frame, not several.
- **Stable input:** after the first frame, a constant `snap` produces no further traffic.

## Timing
- **Reset values:** `seg_clk`=0, `seg_sout`=0, `seg_pen`=0, `seg_clrn`=0, `busy`=0, state IDLE, `valid`=0.
- **`seg_clrn`:** goes to 1 on the first `clk` edge after `rst` deasserts, and stays 1.
- **Trigger and busy:** the IDLE trigger is detected at edge N; `busy`=1 from edge N through the last LATCH cycle.
  - Busy duration is 64·2·CLK_DIV + 2·CLK_DIV cycles; with CLK_DIV=2 that is 260 cycles.
- **Edge spacing:** the first `seg_clk` rising edge occurs CLK_DIV cycles after entering SHIFT.
- **Setup/hold:** `seg_sout` changes only while `seg_clk`=0, and at least CLK_DIV cycles before the rising edge.
- **`seg_pen`:** rises only after the final `seg_clk` falling edge, and never overlaps `seg_clk`=1.
- **Back-to-back frames:** if a change is pending on return to IDLE, the next frame starts on the following edge. Minimum IDLE dwell is 1 cycle.
- **Reset mid-operation:** `rst` asserted in any state immediately forces all reset values.
  - A partial frame is never latched.
  - After release, a full frame is resent because `valid`=0.

## Test plan
- **Reset behaviour:** assert `rst` with CLK_DIV=2. All outputs must be 0, including `seg_clrn`=0. Release reset with disp_num=32'h0000_0000, point=0, le=0.
  - One frame must start: busy high for 260 cycles, 64 `seg_clk` rising edges, then one `seg_pen` pulse 4 cycles wide.
  - Captured bits must be C0 repeated 8 times.
- **Hex decode:** disp_num=32'h1234_ABCD, point=0, le=0. Captured frame must be F9 A4 B0 99 88 83 C6 A1.
- **Point and blank masks:** disp_num=32'h8888_8888, point=8'h01, le=8'h80. Frame must be FF 80 80 80 80 80 80 00.
- **No retransmit on stable input:** hold inputs constant for 2000 cycles after the first frame. There must be no `seg_clk` or `seg_pen` activity and `busy` must stay 0.
- **Changes mid-frame:** change disp_num to 32'h1 and then to 32'h2 during SHIFT.
  - The current frame must complete unchanged.
  - Exactly one follow-up frame with digit0=A4 must be sent, and then the block returns to idle.
- **Reset mid-shift:** pulse `rst` at bit 30.
  - There must be no `seg_pen` pulse during reset.
  - `seg_clrn` must drop to 0 immediately.
  - A full frame must be resent after reset releases.

Source files
------------

// File: rtl/seven_seg_serial_tx.sv
// seven_seg_serial_tx
// Decodes a 32-bit display word into eight active-low seven-segment bytes.
// Shifts the 64-bit frame MSB-first into an external shift-register chain,
// then pulses the latch strobe. A frame is only sent when the displayed
// content (number, points, blanks) differs from the last completed frame.

module seven_seg_serial_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp_num,
    input  logic [7:0]  point,
    input  logic [7:0]  le,
    output logic        seg_clk,
    output logic        seg_sout,
    output logic        seg_pen,
    output logic        seg_clrn,
    output logic        busy
);

    // One divider count spans a whole bit: low half, then high half.
    localparam int DIVW = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [DIVW-1:0] HALF_LAST = DIVW'(CLK_DIV - 1);
    localparam logic [DIVW-1:0] FULL_LAST = DIVW'(2 * CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t          state_q;
    logic [63:0]     shift_q;
    logic [6:0]      cnt_q;
    logic [DIVW-1:0] div_q;
    logic [47:0]     last_q;
    logic [47:0]     pending_q;
    logic            valid_q;
    logic            seg_clk_q;
    logic            seg_pen_q;
    logic            seg_clrn_q;
    logic            busy_q;

    logic [63:0]     frame_d;
    logic [47:0]     snap_d;

    // Hex digit to segments g..a, active-low, decimal point excluded.
    function automatic logic [6:0] hexSeg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Build the full segment frame from the live inputs; blanked digits are all-off.
    always_comb begin
        frame_d = '0;
        for (int i = 0; i < 8; i++) begin
            if (le[i]) begin
                frame_d[8*i +: 8] = 8'hFF;
            end else begin
                frame_d[8*i +: 8] = {~point[i], hexSeg(disp_num[4*i +: 4])};
            end
        end
    end

    assign snap_d = {disp_num, point, le};

    // Transmit FSM: waits for changed content, shifts 64 bits, then latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            div_q      <= '0;
            last_q     <= '0;
            pending_q  <= '0;
            valid_q    <= 1'b0;
            seg_clk_q  <= 1'b0;
            seg_pen_q  <= 1'b0;
            seg_clrn_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            seg_clrn_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (!valid_q || (snap_d != last_q)) begin
                        state_q   <= SHIFT;
                        shift_q   <= frame_d;
                        pending_q <= snap_d;
                        cnt_q     <= '0;
                        div_q     <= '0;
                        seg_clk_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_q == FULL_LAST) begin
                        div_q     <= '0;
                        seg_clk_q <= 1'b0;
                        cnt_q     <= cnt_q + 7'd1;
                        if (cnt_q == 7'd63) begin
                            state_q   <= LATCH;
                            seg_pen_q <= 1'b1;
                        end else begin
                            shift_q <= {shift_q[62:0], 1'b0};
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                        if (div_q == HALF_LAST) begin
                            seg_clk_q <= 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (div_q == FULL_LAST) begin
                        div_q     <= '0;
                        seg_pen_q <= 1'b0;
                        busy_q    <= 1'b0;
                        last_q    <= pending_q;
                        valid_q   <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign seg_clk  = seg_clk_q;
    assign seg_sout = shift_q[63];
    assign seg_pen  = seg_pen_q;
    assign seg_clrn = seg_clrn_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_seven_seg_serial_tx.sv
// Testbench for seven_seg_serial_tx
// Captures frames off the serial pins and compares them with frames computed
// directly from the display rules, plus timing and protocol properties.

module tb_seven_seg_serial_tx;

    localparam int CLK_DIV = 2;
    localparam int BUSY_LEN = 64 * 2 * CLK_DIV + 2 * CLK_DIV;

    logic        clk;
    logic        rst;
    logic [31:0] disp_num;
    logic [7:0]  point;
    logic [7:0]  le;
    logic        seg_clk;
    logic        seg_sout;
    logic        seg_pen;
    logic        seg_clrn;
    logic        busy;

    int assertCount = 0;
    int failCount   = 0;

    // Digit glyphs as full bytes with the point unlit.
    logic [7:0] hexTab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Monitor state
    logic [63:0] bitsAcc;
    int          bitCnt;
    int          penW;
    int          busyW;
    int          stable;
    logic        prevClk, prevPen, prevBusy, prevSout;
    int          clkRises = 0;
    int          penRises = 0;
    int          busySamples = 0;
    int          setupViol = 0;
    int          overlapViol = 0;
    logic [63:0] frameQ [$];
    int          bitsQ [$];
    int          penWQ [$];
    int          busyWQ [$];

    seven_seg_serial_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .disp_num (disp_num),
        .point    (point),
        .le       (le),
        .seg_clk  (seg_clk),
        .seg_sout (seg_sout),
        .seg_pen  (seg_pen),
        .seg_clrn (seg_clrn),
        .busy     (busy)
    );

    // 10 ns system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected frame straight from the display rules: byte i from nibble i.
    function automatic logic [63:0] modelFrame(input logic [31:0] n, input logic [7:0] p,
                                               input logic [7:0] l);
        logic [63:0] fr;
        logic [7:0]  b;
        int          nib;
        fr = '0;
        for (int i = 0; i < 8; i++) begin
            nib = int'((n >> (4 * i)) & 32'hF);
            if (l[i]) b = 8'hFF;
            else      b = (hexTab[nib] & 8'h7F) | (p[i] ? 8'h00 : 8'h80);
            fr = fr | (64'(b) << (8 * i));
        end
        return fr;
    endfunction

    // Watch the serial pins on the falling clk edge and reassemble frames.
    always @(negedge clk) begin
        if (rst) begin
            prevClk = 0; prevPen = 0; prevBusy = 0; prevSout = 0;
            bitCnt = 0; penW = 0; busyW = 0; stable = 0; bitsAcc = '0;
        end else begin
            if (seg_sout != prevSout) stable = 1;
            else                      stable++;
            if (seg_clk && (seg_sout != prevSout)) setupViol++;
            if (seg_clk && !prevClk) begin
                clkRises++;
                bitsAcc = {bitsAcc[62:0], seg_sout};
                bitCnt++;
                if (stable <= CLK_DIV) setupViol++;
            end
            if (seg_pen && seg_clk) overlapViol++;
            if (seg_pen && !prevPen) begin
                penRises++;
                frameQ.push_back(bitsAcc);
                bitsQ.push_back(bitCnt);
                bitCnt = 0;
                bitsAcc = '0;
            end
            if (seg_pen) penW++;
            else if (prevPen) begin
                penWQ.push_back(penW);
                penW = 0;
            end
            if (busy) begin
                busyW++;
                busySamples++;
            end else if (prevBusy) begin
                busyWQ.push_back(busyW);
                busyW = 0;
            end
            prevClk = seg_clk; prevPen = seg_pen; prevBusy = busy; prevSout = seg_sout;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] n, input logic [7:0] p, input logic [7:0] l);
        @(negedge clk);
        #1;
        disp_num = n;
        point    = p;
        le       = l;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Wait for one complete frame (busy falling) and check its content and timing.
    task automatic waitFrame(input string tag, input logic [63:0] expFrame);
        int n;
        n = 0;
        while ((busyWQ.size() == 0) && (n < 3000)) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (busyWQ.size() == 0) begin
            checkOutput({tag, "_timeout"}, 64'(busyWQ.size()), 64'd1);
        end else begin
            checkOutput({tag, "_frame"}, (frameQ.size() > 0) ? frameQ.pop_front() : 64'd0, expFrame);
            checkOutput({tag, "_bits"},  64'((bitsQ.size() > 0) ? bitsQ.pop_front() : 0), 64'd64);
            checkOutput({tag, "_penW"},  64'((penWQ.size() > 0) ? penWQ.pop_front() : 0), 64'(2 * CLK_DIV));
            checkOutput({tag, "_busyW"}, 64'(busyWQ.pop_front()), 64'(BUSY_LEN));
        end
    endtask

    initial begin
        int c0, p0, b0, n;
        logic [31:0] rn;
        logic [7:0]  rp, rl;

        // Reset with all-zero inputs
        rst = 1'b1;
        disp_num = '0;
        point = '0;
        le = '0;
        waitCycles(3);
        checkOutput("rst_seg_clk",  64'(seg_clk),  64'd0);
        checkOutput("rst_seg_sout", 64'(seg_sout), 64'd0);
        checkOutput("rst_seg_pen",  64'(seg_pen),  64'd0);
        checkOutput("rst_seg_clrn", 64'(seg_clrn), 64'd0);
        checkOutput("rst_busy",     64'(busy),     64'd0);
        rst = 1'b0;
        waitCycles(1);
        checkOutput("clrn_release", 64'(seg_clrn), 64'd1);
        checkOutput("busy_first",   64'(busy),     64'd1);
        waitFrame("first", modelFrame(32'h0, 8'h00, 8'h00));

        // Hex decode
        applyStimulus(32'h1234_ABCD, 8'h00, 8'h00);
        waitFrame("hex", modelFrame(32'h1234_ABCD, 8'h00, 8'h00));

        // Point and blank masks
        applyStimulus(32'h8888_8888, 8'h01, 8'h80);
        waitFrame("mask", modelFrame(32'h8888_8888, 8'h01, 8'h80));

        // Stable input produces no traffic
        c0 = clkRises;
        p0 = penRises;
        b0 = busySamples;
        waitCycles(2000);
        checkOutput("stable_clk",  64'(clkRises - c0),    64'd0);
        checkOutput("stable_pen",  64'(penRises - p0),    64'd0);
        checkOutput("stable_busy", 64'(busySamples - b0), 64'd0);

        // Two changes mid-frame collapse into one follow-up frame
        applyStimulus(32'h0, 8'h00, 8'h00);
        n = 0;
        while (!busy && n < 10) begin
            waitCycles(1);
            n++;
        end
        checkOutput("mid_started", 64'(busy), 64'd1);
        waitCycles(40);
        applyStimulus(32'h1, 8'h00, 8'h00);
        waitCycles(80);
        applyStimulus(32'h2, 8'h00, 8'h00);
        waitFrame("mid_a", modelFrame(32'h0, 8'h00, 8'h00));
        waitFrame("mid_b", modelFrame(32'h2, 8'h00, 8'h00));
        p0 = penRises;
        waitCycles(600);
        checkOutput("mid_extra_pen", 64'(penRises - p0), 64'd0);
        checkOutput("mid_idle_busy", 64'(busy), 64'd0);

        // Reset in the middle of shifting
        applyStimulus(32'hCAFE_F00D, 8'h5A, 8'h03);
        n = 0;
        while (bitCnt < 30 && n < 1000) begin
            waitCycles(1);
            n++;
        end
        checkOutput("rmid_bitcnt", 64'(bitCnt), 64'd30);
        rst = 1'b1;
        #1;
        checkOutput("rmid_clrn", 64'(seg_clrn), 64'd0);
        checkOutput("rmid_sclk", 64'(seg_clk),  64'd0);
        checkOutput("rmid_busy", 64'(busy),     64'd0);
        p0 = penRises;
        for (int i = 0; i < 3; i++) begin
            waitCycles(1);
            checkOutput("rmid_pen", 64'(seg_pen), 64'd0);
        end
        checkOutput("rmid_no_latch", 64'(penRises - p0), 64'd0);
        rst = 1'b0;
        waitFrame("rmid_resend", modelFrame(32'hCAFE_F00D, 8'h5A, 8'h03));

        // Randomised content
        for (int k = 0; k < 6; k++) begin
            rn = $urandom;
            rp = 8'($urandom);
            rl = 8'($urandom_range(0, 255));
            applyStimulus(rn, rp, rl);
            waitFrame($sformatf("rand%0d", k), modelFrame(rn, rp, rl));
        end

        checkOutput("setup_hold", 64'(setupViol),   64'd0);
        checkOutput("pen_overlap", 64'(overlapViol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
